// File: rtl/uart_tx_arbiter_if.sv
// Bundle of the requester-side and transmitter-side signals around the
// shared uart_tx arbiter. The arbiter uses the slave modport and the
// surrounding logic (requesters plus the uart_tx instance) uses the
// master modport.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   ack;
  logic                 err;
  logic                 uart_send_sig;
  logic [7:0]           uart_data;
  logic                 uart_tx_busy;
  logic                 uart_tx_done;
  logic                 arb_busy;

  modport slave (
    input  req,
    input  req_data,
    input  uart_tx_busy,
    input  uart_tx_done,
    output grant,
    output ack,
    output err,
    output uart_send_sig,
    output uart_data,
    output arb_busy
  );

  modport master (
    output req,
    output req_data,
    output uart_tx_busy,
    output uart_tx_done,
    input  grant,
    input  ack,
    input  err,
    input  uart_send_sig,
    input  uart_data,
    input  arb_busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ requesters.
// One byte is launched per grant; the winner gets a one-cycle ack once
// the transmitter reports done, or once a watchdog gives up on it (in
// which case err pulses alongside the ack).
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 87,
  parameter int TIMEOUT_CLKS = 12 * CLKS_PER_BIT
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_arbiter_if.slave   bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    ACK       = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 err_q, err_d;
  logic                 send_q, send_d;
  logic [7:0]           data_q, data_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 found;
  logic [IDX_W-1:0]     win;

  // Search for the next requester starting just after the last winner,
  // wrapping around, so the previous winner ends up with lowest priority.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      logic [IDX_W-1:0] cand;
      cand = IDX_W'((int'(rr_q) + k) % NUM_REQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Next-state and next-output logic; every register holds by default
  // except the single-cycle pulses (ack, err, send), which default low.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ack_d   = '0;
    err_d   = 1'b0;
    send_d  = 1'b0;
    data_d  = data_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (found && !bus.uart_tx_busy) begin
          grant_d      = '0;
          grant_d[win] = 1'b1;
          data_d       = bus.req_data[{win, 3'b000} +: 8];
          send_d       = 1'b1;
          rr_d         = win;
          cnt_d        = '0;
          state_d      = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        if (bus.uart_tx_done) begin
          ack_d   = grant_q;
          state_d = ACK;
        end else if (cnt_q == CNT_LAST) begin
          ack_d   = grant_q;
          err_d   = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ACK: begin
        grant_d = '0;
        state_d = IDLE;
      end

      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer without an ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      send_q  <= 1'b0;
      data_q  <= '0;
      rr_q    <= PTR_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      send_q  <= send_d;
      data_q  <= data_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.grant         = grant_q;
  assign bus.ack           = ack_q;
  assign bus.err           = err_q;
  assign bus.uart_send_sig = send_q;
  assign bus.uart_data     = data_q;
  assign bus.arb_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter. The uart_tx is replaced by bench-driven
// busy/done stimulus; CLKS_PER_BIT=4 gives a 48-clock watchdog.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ      (4),
    .CLKS_PER_BIT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 10 time-unit clock
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    bus.req          = '0;
    bus.req_data     = '0;
    bus.uart_tx_busy = 1'b0;
    bus.uart_tx_done = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [3:0] req_val, input logic [31:0] data_val);
    bus.req      = req_val;
    bus.req_data = data_val;
  endtask

  // From IDLE with requests pending: launch, finish via done, ack, return to IDLE
  task automatic serve_one(input string tag, input logic [3:0] exp_grant,
                           input logic [7:0] exp_byte);
    tick(1);
    check_output({tag, "_grant"}, 32'(bus.grant), 32'(exp_grant));
    check_output({tag, "_send"}, 32'(bus.uart_send_sig), 32'd1);
    check_output({tag, "_data"}, 32'(bus.uart_data), 32'(exp_byte));
    check_output({tag, "_onehot"}, 32'($onehot0(bus.grant)), 32'd1);
    tick(1);
    check_output({tag, "_send_clr"}, 32'(bus.uart_send_sig), 32'd0);
    bus.uart_tx_done = 1'b1;
    tick(1);
    bus.uart_tx_done = 1'b0;
    check_output({tag, "_ack"}, 32'(bus.ack), 32'(exp_grant));
    check_output({tag, "_err"}, 32'(bus.err), 32'd0);
    check_output({tag, "_grant_hold"}, 32'(bus.grant), 32'(exp_grant));
    tick(1);
    check_output({tag, "_ack_clr"}, 32'(bus.ack), 32'd0);
    check_output({tag, "_grant_clr"}, 32'(bus.grant), 32'd0);
    check_output({tag, "_idle"}, 32'(bus.arb_busy), 32'd0);
  endtask

  initial begin
    logic seen;

    // Reset values
    do_reset();
    check_output("rst_grant", 32'(bus.grant), 32'd0);
    check_output("rst_ack", 32'(bus.ack), 32'd0);
    check_output("rst_err", 32'(bus.err), 32'd0);
    check_output("rst_send", 32'(bus.uart_send_sig), 32'd0);
    check_output("rst_data", 32'(bus.uart_data), 32'd0);
    check_output("rst_busy", 32'(bus.arb_busy), 32'd0);

    // Single requester 0 with byte 0xAB
    apply_stimulus(4'b0001, 32'h0000_00AB);
    serve_one("t1", 4'b0001, 8'hAB);
    apply_stimulus(4'b0000, 32'h0000_00AB);
    tick(1);
    check_output("t1_no_relaunch", 32'(bus.grant), 32'd0);

    // All four held: rotation 0,1,2,3,0
    do_reset();
    apply_stimulus(4'b1111, 32'h4332_2110);
    serve_one("t2_r0", 4'b0001, 8'h10);
    serve_one("t2_r1", 4'b0010, 8'h21);
    serve_one("t2_r2", 4'b0100, 8'h32);
    serve_one("t2_r3", 4'b1000, 8'h43);
    serve_one("t2_r0b", 4'b0001, 8'h10);
    apply_stimulus(4'b0000, 32'h0);

    // Wrap: after 2 wins, 0101 serves 0 then 2; data captured only at grant
    do_reset();
    apply_stimulus(4'b0100, 32'h00C3_005A);
    serve_one("t3_r2", 4'b0100, 8'hC3);
    apply_stimulus(4'b0101, 32'h00C3_005A);
    tick(1);
    check_output("t3_wrap_grant", 32'(bus.grant), 32'b0001);
    check_output("t3_wrap_data", 32'(bus.uart_data), 32'h5A);
    bus.req_data = 32'h00C3_00FF;
    tick(1);
    check_output("t3_capture", 32'(bus.uart_data), 32'h5A);
    bus.uart_tx_done = 1'b1;
    tick(1);
    bus.uart_tx_done = 1'b0;
    check_output("t3_wrap_ack", 32'(bus.ack), 32'b0001);
    tick(1);
    serve_one("t3_next", 4'b0100, 8'hC3);
    apply_stimulus(4'b0000, 32'h0);

    // Transmitter busy for 50 clocks blocks the launch
    apply_stimulus(4'b0010, 32'h0000_9900);
    bus.uart_tx_busy = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (bus.uart_send_sig || bus.grant != 4'b0000) seen = 1'b1;
    end
    check_output("t4_no_launch_busy", 32'(seen), 32'd0);
    bus.uart_tx_busy = 1'b0;
    serve_one("t4_after_busy", 4'b0010, 8'h99);
    apply_stimulus(4'b0000, 32'h0);

    // Watchdog: no done, ack+err 48 clocks after launch; req drop ignored
    apply_stimulus(4'b1000, 32'h7700_0000);
    tick(1);
    check_output("t5_grant", 32'(bus.grant), 32'b1000);
    bus.req = 4'b0000;
    seen = 1'b0;
    for (int i = 0; i < 47; i++) begin
      tick(1);
      if (bus.ack != 4'b0000 || bus.err) seen = 1'b1;
    end
    check_output("t5_no_early_ack", 32'(seen), 32'd0);
    tick(1);
    check_output("t5_to_ack", 32'(bus.ack), 32'b1000);
    check_output("t5_to_err", 32'(bus.err), 32'd1);
    tick(1);
    check_output("t5_ack_clr", 32'(bus.ack), 32'd0);
    check_output("t5_err_clr", 32'(bus.err), 32'd0);
    check_output("t5_idle", 32'(bus.arb_busy), 32'd0);

    // Done on the timeout edge: done wins, err stays low
    apply_stimulus(4'b1000, 32'h7700_0000);
    tick(1);
    bus.req = 4'b0000;
    tick(47);
    bus.uart_tx_done = 1'b1;
    tick(1);
    bus.uart_tx_done = 1'b0;
    check_output("t5_tie_ack", 32'(bus.ack), 32'b1000);
    check_output("t5_tie_err", 32'(bus.err), 32'd0);
    tick(1);

    // Done while idle is ignored, then the next request is served
    bus.uart_tx_done = 1'b1;
    tick(1);
    bus.uart_tx_done = 1'b0;
    check_output("t5_idle_done_ack", 32'(bus.ack), 32'd0);
    check_output("t5_idle_done_busy", 32'(bus.arb_busy), 32'd0);
    apply_stimulus(4'b0001, 32'h0000_0066);
    serve_one("t5_next", 4'b0001, 8'h66);
    apply_stimulus(4'b0000, 32'h0);

    // Reset in WAIT_DONE aborts without ack; pointer returns to NUM_REQ-1
    apply_stimulus(4'b0100, 32'h4332_2110);
    tick(1);
    check_output("t6_grant", 32'(bus.grant), 32'b0100);
    tick(1);
    reset   = 1'b1;
    bus.req = 4'b0000;
    tick(1);
    reset = 1'b0;
    check_output("t6_grant_rst", 32'(bus.grant), 32'd0);
    check_output("t6_ack_rst", 32'(bus.ack), 32'd0);
    check_output("t6_send_rst", 32'(bus.uart_send_sig), 32'd0);
    check_output("t6_data_rst", 32'(bus.uart_data), 32'd0);
    check_output("t6_busy_rst", 32'(bus.arb_busy), 32'd0);
    bus.uart_tx_done = 1'b1;
    tick(1);
    bus.uart_tx_done = 1'b0;
    check_output("t6_no_ack", 32'(bus.ack), 32'd0);
    apply_stimulus(4'b1111, 32'h4332_2110);
    serve_one("t6_after", 4'b0001, 8'h10);
    apply_stimulus(4'b0000, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx transmitter among NUM_REQ on-chip requesters.
- Arbitrates round-robin and launches one byte per grant through the uart_tx send_sig/data handshake.
- Waits for uart_tx tx_done, then returns a one-cycle ack to the winning requester.
- Sits between bus-side byte producers and the uart_tx instance. A watchdog recovers from a transmitter that never completes.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CLKS_PER_BIT, 87, clocks per UART bit; must match the uart_tx clks_per_bit (10 MHz / 115200).
- TIMEOUT_CLKS, 12*CLKS_PER_BIT, max clocks to wait for uart_tx_done after launch.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req  input  NUM_REQ  per-requester byte-send request, level
- req_data  input  8*NUM_REQ  byte for requester i at bits [8i+7:8i]
- grant  output  NUM_REQ  one-hot, high while requester owns the transmitter
- ack  output  NUM_REQ  one-cycle pulse, byte finished for that requester
- err  output  1  one-cycle pulse coincident with ack when completion was by timeout
- uart_send_sig  output  1  launch pulse to uart_tx send_sig
- uart_data  output  8  byte to uart_tx data, held from launch until ack
- uart_tx_busy  input  1  uart_tx tx_busy
- uart_tx_done  input  1  uart_tx tx_done (one-cycle pulse)
- arb_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset is synchronous and active-high; clock is clk.
- Reset values: state=IDLE, grant=0, ack=0, err=0, uart_send_sig=0, uart_data=0, arb_busy=0, rr_ptr=NUM_REQ-1, timeout counter=0.
- Reset mid-transfer aborts immediately. No ack is issued.
- States: IDLE, WAIT_DONE, ACK.

IDLE:
- At an edge where req!=0 and uart_tx_busy==0:
  - Winner w = first set req bit searching from (rr_ptr+1) mod NUM_REQ upward with wrap.
  - Registers set: grant=onehot(w), uart_data=req_data[8w+7:8w], uart_send_sig=1, rr_ptr=w, counter=0.
  - Next state WAIT_DONE.
- Latency: req high before edge E gives grant and send_sig visible after E. This is 1 clock.
- If uart_tx_busy==1, no launch occurs and requests stay pending.

WAIT_DONE:
- uart_send_sig is high for exactly one cycle; it is cleared at the next edge.
- Counter increments each cycle.
- When uart_tx_done==1 at an edge: ack[w]=1, grant unchanged, next state ACK.
- When counter reaches TIMEOUT_CLKS-1 without done: ack[w]=1, err=1, next state ACK.
- If done and timeout fall on the same edge, done wins and err=0.
- Dropping req[w] here is ignored. The byte completes and is acked.

ACK:
- Lasts one cycle. At the next edge: ack=0, err=0, grant=0, next state IDLE.
- uart_data is retained until the next launch.

Requester contract:
- Hold req and req_data stable until ack.
- Deassert req at the edge ack is sampled, or keep req high with a new req_data to stream. A held req counts as a new request.
- req_data is captured only at grant; later changes do not affect the byte in flight.

Fairness:
- rr_ptr makes the last winner lowest priority.
- With all requesters continuously active, grants rotate 0,1,2,3,0...
- Minimum gap between consecutive launches is 2 clocks after done (ACK, IDLE).

Other rules:
- uart_tx_done while in IDLE or ACK is ignored.
- Only bit w of ack is ever set. grant is always one-hot or zero.

Test Plan:
1. Reset, then req=4'b0001 with byte 0xAB → after 1 clk, grant=0001, uart_send_sig pulses 1 cycle, uart_data=0xAB. Against a real uart_tx, the serial line shows frame 0xAB. ack[0] pulses 1 cycle after tx_done. err=0.
2. req=4'b1111 held continuously, bytes 0x10,0x21,0x32,0x43 → launch order is requesters 0,1,2,3,0. Each ack matches its byte on the serial line. Never two grants at once.
3. After requester 2 wins, req=4'b0101 → next grant goes to requester 0 (search wraps from 3). The following grant goes to requester 2.
4. Hold uart_tx_busy=1 for 50 clks while req=0010 → no send_sig during busy. Launch occurs on the first edge after busy falls.
5. Stub uart_tx_done never asserted, CLKS_PER_BIT=4 (TIMEOUT_CLKS=48) → ack and err pulse together 48 clks after launch. Arbiter returns to IDLE and serves the next request.
6. Assert reset for 1 clk in WAIT_DONE → next cycle all outputs are 0 and no ack is issued. rr_ptr=NUM_REQ-1, so requester 0 wins the subsequent req=1111.
